sdram_arbiter: RTL

- Command-bus owner for the SDRAM controller: sequences initialisation, auto-refresh, write and read sub-blocks onto one shared command/address bus.
- Each sub-block (refresh, write, read) raises a req; the arbiter grants via en and releases on ack.
- Sits between the init/refresh/write/read sub-blocks and the SDRAM pin registers.
- Adds write/read alternation and a grant watchdog.

---
 rtl/sdram_pkg.sv | 29 ++
 rtl/sdram_arb_pick.sv | 32 +++
 rtl/sdram_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, arbiter state encoding and default widths.
// Commands are {CKE, CS_N, RAS_N, CAS_N, WE_N}.
package sdram_pkg;

    localparam int ADDR_W_DEF = 12;

    localparam logic [4:0] CMD_NOP   = 5'b10111;
    localparam logic [4:0] CMD_PREC  = 5'b10010;
    localparam logic [4:0] CMD_AREF  = 5'b10001;
    localparam logic [4:0] CMD_ACT   = 5'b10011;
    localparam logic [4:0] CMD_WRITE = 5'b10100;
    localparam logic [4:0] CMD_READ  = 5'b10101;
    localparam logic [4:0] CMD_MRS   = 5'b10000;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_AREF,
        ST_WRITE,
        ST_READ
    } arb_state_t;

    typedef struct packed {
        logic aref;
        logic wr;
        logic rd;
    } grant_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational request picker: refresh first, then write/read alternation
// when both are pending. Output is one-hot {aref, wr, rd}, or zero.
module sdram_arb_pick
    import sdram_pkg::*;
(
    input  logic       aref_req,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic       last_wr,
    output logic [2:0] grant
);

    grant_t pick;

    always_comb begin
        pick = '0;
        if (aref_req) begin
            pick.aref = 1'b1;
        end else if (wr_req && rd_req) begin
            // Serve whichever side was not served last.
            pick.rd = last_wr;
            pick.wr = ~last_wr;
        end else if (wr_req) begin
            pick.wr = 1'b1;
        end else if (rd_req) begin
            pick.rd = 1'b1;
        end
    end

    assign grant = pick;

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: init pass-through, then refresh/write/read grants
// with a per-grant ack watchdog and registered command/address outputs.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 1023,
    parameter int          ADDR_W      = ADDR_W_DEF
) (
    input  logic              S_CLK,
    input  logic              RST,
    input  logic              flag_init,
    input  logic [4:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    output logic              aref_en,
    input  logic              aref_ack,
    input  logic [4:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    output logic              wr_en,
    input  logic              wr_ack,
    input  logic [4:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_req,
    output logic              rd_en,
    input  logic              rd_ack,
    input  logic [4:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [4:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              arb_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    arb_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              last_wr, last_wr_nxt;
    logic              err_nxt;
    logic              ack;
    logic [2:0]        pick;
    logic [4:0]        mux_cmd;
    logic [ADDR_W-1:0] mux_addr;

    sdram_arb_pick u_pick (
        .aref_req (aref_req),
        .wr_req   (wr_req),
        .rd_req   (rd_req),
        .last_wr  (last_wr),
        .grant    (pick)
    );

    always_ff @(posedge S_CLK) begin
        if (RST) begin
            state      <= ST_INIT;
            cnt        <= '0;
            last_wr    <= 1'b0;
            arb_err    <= 1'b0;
            aref_en    <= 1'b0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            sdram_cmd  <= CMD_NOP;
            sdram_addr <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_wr    <= last_wr_nxt;
            arb_err    <= err_nxt;
            aref_en    <= (state_nxt == ST_AREF);
            wr_en      <= (state_nxt == ST_WRITE);
            rd_en      <= (state_nxt == ST_READ);
            sdram_cmd  <= mux_cmd;
            sdram_addr <= mux_addr;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_wr_nxt = last_wr;
        err_nxt     = arb_err;
        ack         = 1'b0;
        mux_cmd     = CMD_NOP;
        mux_addr    = '0;

        case (state)
            ST_INIT: begin
                mux_cmd  = init_cmd;
                mux_addr = init_addr;
                if (flag_init) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                cnt_nxt = '0;
                if (pick[2])      state_nxt = ST_AREF;
                else if (pick[1]) state_nxt = ST_WRITE;
                else if (pick[0]) state_nxt = ST_READ;
            end
            ST_AREF: begin
                mux_cmd  = aref_cmd;
                mux_addr = aref_addr;
                ack      = aref_ack;
            end
            ST_WRITE: begin
                mux_cmd  = wr_cmd;
                mux_addr = wr_addr;
                ack      = wr_ack;
            end
            ST_READ: begin
                mux_cmd  = rd_cmd;
                mux_addr = rd_addr;
                ack      = rd_ack;
            end
            default: state_nxt = ST_INIT;
        endcase

        // Ack takes precedence over a watchdog expiry in the same cycle.
        if (state == ST_AREF || state == ST_WRITE || state == ST_READ) begin
            if (ack || cnt == CNT_LAST) begin
                state_nxt = ST_IDLE;
                if (!ack) err_nxt = 1'b1;
                if (state == ST_WRITE) last_wr_nxt = 1'b1;
                if (state == ST_READ)  last_wr_nxt = 1'b0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

endmodule
